// File: rtl/ex_csr_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ex_csr_regfile                                              |
// | Brief    : Machine-mode CSR file with trap/mret state and counters.    |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module ex_csr_regfile #(
  parameter int              XLEN     = 32,
  parameter int              HARTID   = 0,
  parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_1105
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_ena,
  input  logic            csr_wr_en,
  input  logic            csr_rd_en,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] wbck_csr_dat,
  output logic [XLEN-1:0] read_csr_dat,
  output logic            csr_access_ilgl,
  input  logic            cmt_instret_ena,
  input  logic            cmt_trap_ena,
  input  logic [XLEN-1:0] cmt_trap_epc,
  input  logic [XLEN-1:0] cmt_trap_cause,
  input  logic [XLEN-1:0] cmt_trap_tval,
  input  logic            cmt_mret_ena,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            sft_irq,
  output logic [XLEN-1:0] csr_mtvec_r,
  output logic [XLEN-1:0] csr_mepc_r,
  output logic            status_mie_r
);

  localparam logic [11:0] c_addr_mstatus   = 12'h300;
  localparam logic [11:0] c_addr_misa      = 12'h301;
  localparam logic [11:0] c_addr_mie       = 12'h304;
  localparam logic [11:0] c_addr_mtvec     = 12'h305;
  localparam logic [11:0] c_addr_mcntinh   = 12'h320;
  localparam logic [11:0] c_addr_mscratch  = 12'h340;
  localparam logic [11:0] c_addr_mepc      = 12'h341;
  localparam logic [11:0] c_addr_mcause    = 12'h342;
  localparam logic [11:0] c_addr_mtval     = 12'h343;
  localparam logic [11:0] c_addr_mip       = 12'h344;
  localparam logic [11:0] c_addr_mcycle    = 12'hB00;
  localparam logic [11:0] c_addr_minstret  = 12'hB02;
  localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_addr_minstreth = 12'hB82;
  localparam logic [11:0] c_addr_mhartid   = 12'hF14;

  localparam logic [XLEN-1:0]   c_mie_mask = XLEN'(32'h0000_0888);
  localparam logic [2*XLEN-1:0] c_cnt_one  = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic              r_status_mie;
  logic              r_status_mpie;
  logic [XLEN-1:0]   r_mie;
  logic [XLEN-1:0]   r_mtvec;
  logic [XLEN-1:0]   r_mscratch;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mtval;
  logic [2*XLEN-1:0] r_mcycle;
  logic [2*XLEN-1:0] r_minstret;
  logic              r_inhibit_cy;
  logic              r_inhibit_ir;

  logic [XLEN-1:0]   w_rdata;
  logic              w_impl;
  logic              w_ilgl;
  logic              w_wr;
  logic              w_unused;

  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (csr_idx)
      c_addr_mstatus: begin
        w_rdata[12:11] = 2'b11;
        w_rdata[7]     = r_status_mpie;
        w_rdata[3]     = r_status_mie;
      end
      c_addr_misa:      w_rdata = MISA_VAL;
      c_addr_mie:       w_rdata = r_mie;
      c_addr_mtvec:     w_rdata = r_mtvec;
      c_addr_mcntinh: begin
        w_rdata[0] = r_inhibit_cy;
        w_rdata[2] = r_inhibit_ir;
      end
      c_addr_mscratch:  w_rdata = r_mscratch;
      c_addr_mepc:      w_rdata = r_mepc;
      c_addr_mcause:    w_rdata = r_mcause;
      c_addr_mtval:     w_rdata = r_mtval;
      c_addr_mip: begin
        w_rdata[11] = ext_irq;
        w_rdata[7]  = tmr_irq;
        w_rdata[3]  = sft_irq;
      end
      c_addr_mcycle:    w_rdata = r_mcycle[XLEN-1:0];
      c_addr_mcycleh:   w_rdata = r_mcycle[2*XLEN-1:XLEN];
      c_addr_minstret:  w_rdata = r_minstret[XLEN-1:0];
      c_addr_minstreth: w_rdata = r_minstret[2*XLEN-1:XLEN];
      c_addr_mhartid:   w_rdata = XLEN'(HARTID);
      default:          w_impl  = 1'b0;
    endcase
  end

  // Address space 0xC00-0xFFF is read-only; misa/mip writes are silently ignored.
  assign w_ilgl = csr_ena & (~w_impl | (csr_wr_en & (csr_idx[11:10] == 2'b11)));
  assign w_wr   = csr_ena & csr_wr_en & ~w_ilgl & ~cmt_trap_ena;

  assign read_csr_dat    = w_rdata;
  assign csr_access_ilgl = w_ilgl;
  assign csr_mtvec_r     = r_mtvec;
  assign csr_mepc_r      = r_mepc;
  assign status_mie_r    = r_status_mie;
  assign w_unused        = ^{csr_rd_en, cmt_trap_epc[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status_mie  <= 1'b0;
      r_status_mpie <= 1'b0;
    end else if (cmt_trap_ena) begin
      r_status_mpie <= r_status_mie;
      r_status_mie  <= 1'b0;
    end else if (cmt_mret_ena) begin
      r_status_mie  <= r_status_mpie;
      r_status_mpie <= 1'b1;
    end else if (w_wr && csr_idx == c_addr_mstatus) begin
      r_status_mie  <= wbck_csr_dat[3];
      r_status_mpie <= wbck_csr_dat[7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (cmt_trap_ena) begin
      r_mepc   <= {cmt_trap_epc[XLEN-1:1], 1'b0};
      r_mcause <= cmt_trap_cause;
      r_mtval  <= cmt_trap_tval;
    end else if (w_wr) begin
      if (csr_idx == c_addr_mepc)   r_mepc   <= {wbck_csr_dat[XLEN-1:1], 1'b0};
      if (csr_idx == c_addr_mcause) r_mcause <= wbck_csr_dat;
      if (csr_idx == c_addr_mtval)  r_mtval  <= wbck_csr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mie        <= '0;
      r_mtvec      <= '0;
      r_mscratch   <= '0;
      r_inhibit_cy <= 1'b0;
      r_inhibit_ir <= 1'b0;
    end else if (w_wr) begin
      if (csr_idx == c_addr_mie)      r_mie      <= wbck_csr_dat & c_mie_mask;
      if (csr_idx == c_addr_mtvec)    r_mtvec    <= {wbck_csr_dat[XLEN-1:2], 2'b00};
      if (csr_idx == c_addr_mscratch) r_mscratch <= wbck_csr_dat;
      if (csr_idx == c_addr_mcntinh) begin
        r_inhibit_cy <= wbck_csr_dat[0];
        r_inhibit_ir <= wbck_csr_dat[2];
      end
    end
  end

  // A write to either half replaces that cycle's increment, so no carry on write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcycle <= '0;
    end else if (w_wr && csr_idx == c_addr_mcycle) begin
      r_mcycle[XLEN-1:0] <= wbck_csr_dat;
    end else if (w_wr && csr_idx == c_addr_mcycleh) begin
      r_mcycle[2*XLEN-1:XLEN] <= wbck_csr_dat;
    end else if (!r_inhibit_cy) begin
      r_mcycle <= r_mcycle + c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_minstret <= '0;
    end else if (w_wr && csr_idx == c_addr_minstret) begin
      r_minstret[XLEN-1:0] <= wbck_csr_dat;
    end else if (w_wr && csr_idx == c_addr_minstreth) begin
      r_minstret[2*XLEN-1:XLEN] <= wbck_csr_dat;
    end else if (cmt_instret_ena && !r_inhibit_ir) begin
      r_minstret <= r_minstret + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_csr_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_ex_csr_regfile                                           |
// | Brief    : Directed and random checks of ex_csr_regfile vs a model.    |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_ex_csr_regfile;

  localparam int          HARTID_T = 3;
  localparam logic [31:0] MISA_T   = 32'h4000_1105;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_ena = 1'b0, csr_wr_en = 1'b0, csr_rd_en = 1'b0;
  logic [11:0] csr_idx = '0;
  logic [31:0] wbck_csr_dat = '0;
  logic [31:0] read_csr_dat;
  logic        csr_access_ilgl;
  logic        cmt_instret_ena = 1'b0, cmt_trap_ena = 1'b0, cmt_mret_ena = 1'b0;
  logic [31:0] cmt_trap_epc = '0, cmt_trap_cause = '0, cmt_trap_tval = '0;
  logic        ext_irq = 1'b0, tmr_irq = 1'b0, sft_irq = 1'b0;
  logic [31:0] csr_mtvec_r, csr_mepc_r;
  logic        status_mie_r;

  int n_assert = 0;
  int n_fail   = 0;

  ex_csr_regfile #(.XLEN(32), .HARTID(HARTID_T), .MISA_VAL(MISA_T)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
    .csr_idx(csr_idx), .wbck_csr_dat(wbck_csr_dat),
    .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl),
    .cmt_instret_ena(cmt_instret_ena), .cmt_trap_ena(cmt_trap_ena),
    .cmt_trap_epc(cmt_trap_epc), .cmt_trap_cause(cmt_trap_cause),
    .cmt_trap_tval(cmt_trap_tval), .cmt_mret_ena(cmt_mret_ena),
    .ext_irq(ext_irq), .tmr_irq(tmr_irq), .sft_irq(sft_irq),
    .csr_mtvec_r(csr_mtvec_r), .csr_mepc_r(csr_mepc_r),
    .status_mie_r(status_mie_r)
  );

  always #10 clk = ~clk;

  // Architectural reference state
  logic        m_mie = 0, m_mpie = 0;
  logic [31:0] m_mie_reg = 0, m_mtvec = 0, m_mscratch = 0;
  logic [31:0] m_mepc = 0, m_mcause = 0, m_mtval = 0, m_inh = 0;
  logic [63:0] m_cyc = 0, m_ins = 0;

  function automatic logic model_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
      12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_ilgl();
    return csr_ena && (!model_impl(csr_idx) || (csr_wr_en && csr_idx >= 12'hC00));
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return MISA_T;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h320: return m_inh;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(ext_irq) << 11) | (32'(tmr_irq) << 7) | (32'(sft_irq) << 3);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF14: return 32'(HARTID_T);
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic        ok;
    logic [31:0] d;
    d  = wbck_csr_dat;
    ok = csr_ena && csr_wr_en && !model_ilgl() && !cmt_trap_ena;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
    end else begin
      if (ok && csr_idx == 12'hB00)      m_cyc[31:0]  = d;
      else if (ok && csr_idx == 12'hB80) m_cyc[63:32] = d;
      else if (!m_inh[0])                m_cyc = m_cyc + 64'd1;
      if (ok && csr_idx == 12'hB02)      m_ins[31:0]  = d;
      else if (ok && csr_idx == 12'hB82) m_ins[63:32] = d;
      else if (cmt_instret_ena && !m_inh[2]) m_ins = m_ins + 64'd1;
      if (cmt_trap_ena) begin
        m_mpie = m_mie; m_mie = 0;
        m_mepc = cmt_trap_epc & ~32'd1; m_mcause = cmt_trap_cause; m_mtval = cmt_trap_tval;
      end else begin
        if (cmt_mret_ena) begin
          m_mie = m_mpie; m_mpie = 1;
        end else if (ok && csr_idx == 12'h300) begin
          m_mie = d[3]; m_mpie = d[7];
        end
        if (ok) begin
          case (csr_idx)
            12'h304: m_mie_reg  = d & 32'h888;
            12'h305: m_mtvec    = d & ~32'd3;
            12'h320: m_inh      = d & 32'h5;
            12'h340: m_mscratch = d;
            12'h341: m_mepc     = d & ~32'd1;
            12'h342: m_mcause   = d;
            12'h343: m_mtval    = d;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_ena = 0; csr_wr_en = 0; csr_idx = a;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_ena = 1; csr_wr_en = 1; csr_idx = a; wbck_csr_dat = d;
    #1;
    check("wr_ilgl", 32'(csr_access_ilgl), 32'(model_ilgl()));
    tick();
    csr_ena = 0; csr_wr_en = 0;
  endtask

  logic [11:0] idx_tab [0:19];

  initial begin
    idx_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                12'hF14, 12'h7C0, 12'hB03, 12'h000, 12'h305, 12'h300};
    #1;
    repeat (3) tick();
    check("rst_mtvec", csr_mtvec_r, 32'h0);
    check("rst_mepc", csr_mepc_r, 32'h0);
    check("rst_mie", 32'(status_mie_r), 32'h0);

    rst_n = 1;
    repeat (10) tick();
    rd(12'hB00); check("idle_mcycle", read_csr_dat, 32'd10);
    rd(12'h300); check("idle_mstatus", read_csr_dat, 32'h0000_1800);
    rd(12'h301); check("idle_misa", read_csr_dat, 32'h4000_1105);

    wr(12'h305, 32'h8000_0103);
    rd(12'h305); check("mtvec_rd", read_csr_dat, 32'h8000_0100);
    check("mtvec_port", csr_mtvec_r, 32'h8000_0100);

    csr_ena = 1; csr_wr_en = 1; csr_idx = 12'hF14; wbck_csr_dat = 32'd5;
    #1; check("hartid_wr_ilgl", 32'(csr_access_ilgl), 32'd1);
    tick();
    rd(12'hF14); check("hartid_rd", read_csr_dat, 32'(HARTID_T));
    csr_ena = 1; csr_idx = 12'h7C0;
    #1; check("unimpl_ilgl", 32'(csr_access_ilgl), 32'd1);
    check("unimpl_rd", read_csr_dat, 32'h0);
    csr_ena = 0;

    wr(12'h300, 32'h8);
    cmt_trap_ena = 1; cmt_trap_epc = 32'h2001; cmt_trap_cause = 32'd11; cmt_trap_tval = 32'hDEAD;
    tick();
    cmt_trap_ena = 0;
    rd(12'h341); check("trap_mepc", read_csr_dat, 32'h2000);
    check("trap_mepc_port", csr_mepc_r, 32'h2000);
    rd(12'h342); check("trap_mcause", read_csr_dat, 32'd11);
    rd(12'h300); check("trap_mstatus", read_csr_dat, 32'h0000_1880);
    cmt_mret_ena = 1;
    tick();
    cmt_mret_ena = 0;
    rd(12'h300); check("mret_mstatus", read_csr_dat, 32'h0000_1888);
    check("mret_mie_port", 32'(status_mie_r), 32'd1);

    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    tick();
    rd(12'hB80); check("carry_mcycleh", read_csr_dat, 32'd1);
    rd(12'hB00); check("carry_mcycle", read_csr_dat, 32'd0);

    wr(12'h340, 32'hAAAA_AAAA);
    csr_ena = 1; csr_wr_en = 1; csr_idx = 12'h340; wbck_csr_dat = 32'h5555_5555;
    cmt_trap_ena = 1; cmt_trap_epc = 32'h3000; cmt_trap_cause = 32'd7; cmt_trap_tval = 32'h1234;
    tick();
    cmt_trap_ena = 0;
    rd(12'h340); check("trapwr_mscratch", read_csr_dat, 32'hAAAA_AAAA);
    rd(12'h341); check("trapwr_mepc", read_csr_dat, 32'h3000);
    rd(12'h342); check("trapwr_mcause", read_csr_dat, 32'd7);
    rd(12'h343); check("trapwr_mtval", read_csr_dat, 32'h1234);

    wr(12'h320, 32'h4);
    cmt_instret_ena = 1;
    repeat (5) tick();
    rd(12'hB02); check("inhibit_minstret", read_csr_dat, model_read(12'hB02));
    rd(12'hB00); check("inhibit_mcycle", read_csr_dat, model_read(12'hB00));
    wr(12'h320, 32'h0);
    repeat (3) tick();
    cmt_instret_ena = 0;
    rd(12'hB02); check("count_minstret", read_csr_dat, model_read(12'hB02));

    for (int i = 0; i < 300; i++) begin
      csr_ena         = ($urandom_range(0, 3) != 0);
      csr_wr_en       = 1'($urandom_range(0, 1));
      csr_rd_en       = 1'($urandom_range(0, 1));
      csr_idx         = idx_tab[$urandom_range(0, 19)];
      wbck_csr_dat    = $urandom;
      cmt_trap_ena    = ($urandom_range(0, 15) == 0);
      cmt_trap_epc    = $urandom;
      cmt_trap_cause  = $urandom;
      cmt_trap_tval   = $urandom;
      cmt_mret_ena    = ($urandom_range(0, 7) == 0);
      cmt_instret_ena = 1'($urandom_range(0, 1));
      ext_irq         = 1'($urandom_range(0, 1));
      tmr_irq         = 1'($urandom_range(0, 1));
      sft_irq         = 1'($urandom_range(0, 1));
      #1;
      check("rnd_rd", read_csr_dat, model_read(csr_idx));
      check("rnd_ilgl", 32'(csr_access_ilgl), 32'(model_ilgl()));
      tick();
      check("rnd_mtvec", csr_mtvec_r, m_mtvec);
      check("rnd_mepc", csr_mepc_r, m_mepc);
      check("rnd_mie", 32'(status_mie_r), 32'(m_mie));
    end
    cmt_trap_ena = 0; cmt_mret_ena = 0; cmt_instret_ena = 0; csr_ena = 0; csr_wr_en = 0;

    wr(12'h320, 32'h0);
    cmt_instret_ena = 1;
    repeat (4) tick();
    rst_n = 0;
    tick();
    rst_n = 1; cmt_instret_ena = 0;
    rd(12'hB00); check("rst_mcycle", read_csr_dat, 32'h0);
    rd(12'hB80); check("rst_mcycleh", read_csr_dat, 32'h0);
    rd(12'hB02); check("rst_minstret", read_csr_dat, 32'h0);
    rd(12'hB82); check("rst_minstreth", read_csr_dat, 32'h0);
    check("rst2_mtvec", csr_mtvec_r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
